// File: rtl/ysyx_23060201_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter in front of a single memory port.
// One outstanding transaction; round-robin between the masters on contention.
module ysyx_23060201_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ifu_req_valid,
    output logic                      ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]     ifu_addr,
    output logic                      ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]     ifu_rdata,
    input  logic                      lsu_req_valid,
    output logic                      lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]     lsu_addr,
    input  logic                      lsu_wen,
    input  logic [DATA_WIDTH-1:0]     lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0]   lsu_wmask,
    output logic                      lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]     lsu_rdata,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_wen,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wmask,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      owner_lsu,
    output logic                      proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic                      grant_ifu_s;
    logic                      grant_lsu_s;
    logic                      last_lsu_r;
    logic                      owner_r;
    logic                      err_r;
    logic [ADDR_WIDTH-1:0]     addr_r;
    logic                      wen_r;
    logic [DATA_WIDTH-1:0]     wdata_r;
    logic [DATA_WIDTH/8-1:0]   wmask_r;

    // Grant selection and next-state decode
    always_comb begin
        state_s     = state_r;
        grant_ifu_s = 1'b0;
        grant_lsu_s = 1'b0;
        case (state_r)
            IDLE: begin
                // On contention the master that was not served last wins
                if (ifu_req_valid && (!lsu_req_valid || last_lsu_r)) begin
                    grant_ifu_s = 1'b1;
                    state_s     = ISSUE;
                end else if (lsu_req_valid) begin
                    grant_lsu_s = 1'b1;
                    state_s     = ISSUE;
                end else begin
                    state_s     = IDLE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, latched request fields, ownership and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            last_lsu_r <= 1'b1;
            owner_r    <= 1'b0;
            err_r      <= 1'b0;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            wen_r      <= 1'b0;
            wdata_r    <= {DATA_WIDTH{1'b0}};
            wmask_r    <= {(DATA_WIDTH/8){1'b0}};
        end else begin
            state_r <= state_s;
            if (grant_ifu_s) begin
                addr_r     <= ifu_addr;
                wen_r      <= 1'b0;
                wdata_r    <= {DATA_WIDTH{1'b0}};
                wmask_r    <= {(DATA_WIDTH/8){1'b0}};
                owner_r    <= 1'b0;
                last_lsu_r <= 1'b0;
            end else if (grant_lsu_s) begin
                addr_r     <= lsu_addr;
                wen_r      <= lsu_wen;
                wdata_r    <= lsu_wdata;
                wmask_r    <= lsu_wmask;
                owner_r    <= 1'b1;
                last_lsu_r <= 1'b1;
            end
            // A response is only legal once the request has been taken by memory
            if (mem_resp_valid && (state_r != WAIT)) begin
                err_r <= 1'b1;
            end
        end
    end

    assign ifu_req_ready  = grant_ifu_s;
    assign lsu_req_ready  = grant_lsu_s;
    assign mem_req_valid  = (state_r == ISSUE);
    assign mem_addr       = addr_r;
    assign mem_wen        = wen_r;
    assign mem_wdata      = wdata_r;
    assign mem_wmask      = wmask_r;
    assign ifu_resp_valid = (state_r == WAIT) && mem_resp_valid && !owner_r;
    assign lsu_resp_valid = (state_r == WAIT) && mem_resp_valid && owner_r;
    assign ifu_rdata      = mem_rdata;
    assign lsu_rdata      = mem_rdata;
    assign owner_lsu      = owner_r;
    assign proto_err      = err_r;

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: directed scenarios
// plus a randomized run against a transaction-level reference model.
module tb_ysyx_23060201_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        owner_lsu, proto_err;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: one pending transaction record plus arbitration history
    logic        m_busy, m_issued, m_own_lsu, m_last_lsu, m_err;
    logic [31:0] m_addr, m_wdata;
    logic        m_wen;
    logic [3:0]  m_wmask;

    ysyx_23060201_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .owner_lsu(owner_lsu), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0;
        lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0; m_issued = 1'b0; m_own_lsu = 1'b0; m_last_lsu = 1'b1; m_err = 1'b0;
        m_addr = 32'h0; m_wen = 1'b0; m_wdata = 32'h0; m_wmask = 4'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        n_total++; if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, owner_lsu, proto_err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {mem_req_valid, ifu_resp_valid, lsu_resp_valid, owner_lsu, proto_err}); else n_pass++;
        n_total++; if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== 69'h0)
            $display("FAIL reset_fields: got %h want 0", {mem_addr, mem_wen, mem_wdata, mem_wmask}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
        #1;
        n_total++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10)
            $display("FAIL fetch_accept: got %b want 10", {ifu_req_ready, lsu_req_ready}); else n_pass++;
        @(negedge clk); ifu_req_valid = 1'b0; #1;
        n_total++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0})
            $display("FAIL fetch_issue: got %b %h %b %h want 1 80000000 0 0", mem_req_valid, mem_addr, mem_wen, mem_wmask); else n_pass++;
        @(negedge clk); mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413; #1;
        n_total++; if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {2'b10, 32'h0000_0413})
            $display("FAIL fetch_resp: got %b%b %h want 10 00000413", ifu_resp_valid, lsu_resp_valid, ifu_rdata); else n_pass++;
        @(negedge clk); mem_resp_valid = 1'b0; #1;
        n_total++; if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid, proto_err} !== 4'b0)
            $display("FAIL fetch_after: got %b want 0000", {ifu_resp_valid, lsu_resp_valid, mem_req_valid, proto_err}); else n_pass++;
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic want_lsu;
            want_lsu = (i % 2) == 1;
            ifu_req_valid = 1'b1; ifu_addr = 32'h100 + i;
            lsu_req_valid = 1'b1; lsu_addr = 32'h200 + i;
            mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
            #1;
            n_total++; if ({ifu_req_ready, lsu_req_ready} !== {!want_lsu, want_lsu})
                $display("FAIL alt_grant[%0d]: got %b want %b", i, {ifu_req_ready, lsu_req_ready}, {!want_lsu, want_lsu}); else n_pass++;
            @(negedge clk); #1;
            n_total++; if ({owner_lsu, mem_req_valid, ifu_req_ready, lsu_req_ready} !== {want_lsu, 3'b100})
                $display("FAIL alt_issue[%0d]: got %b want %b", i, {owner_lsu, mem_req_valid, ifu_req_ready, lsu_req_ready}, {want_lsu, 3'b100}); else n_pass++;
            @(negedge clk); mem_resp_valid = 1'b1; mem_rdata = $urandom; #1;
            n_total++; if ({ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready} !== {!want_lsu, want_lsu, 2'b00})
                $display("FAIL alt_resp[%0d]: got %b want %b", i, {ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}, {!want_lsu, want_lsu, 2'b00}); else n_pass++;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_store_stall();
        int pulses;
        do_reset();
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        #1;
        n_total++; if (lsu_req_ready !== 1'b1)
            $display("FAIL store_accept: got %b want 1", lsu_req_ready); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
            mem_req_ready = (c == 3); #1;
            n_total++; if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011})
                $display("FAIL store_hold[%0d]: got %b %h %b %h %b", c, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask); else n_pass++;
        end
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); mem_req_ready = 1'b0; mem_resp_valid = (c == 0); #1;
            if (lsu_resp_valid === 1'b1) pulses++;
            n_total++; if (ifu_resp_valid !== 1'b0)
                $display("FAIL store_ifu_resp[%0d]: got %b want 0", c, ifu_resp_valid); else n_pass++;
        end
        n_total++; if (pulses !== 1)
            $display("FAIL store_pulses: got %0d want 1", pulses); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        lsu_req_valid = 1'b1; lsu_addr = 32'h1234_5678; lsu_wen = 1'b1; lsu_wdata = 32'hFFFF_0000;
        lsu_wmask = 4'hF; mem_req_ready = 1'b1;
        @(negedge clk); lsu_req_valid = 1'b0;
        @(negedge clk); mem_req_ready = 1'b0; #1;
        n_total++; if ({owner_lsu, mem_req_valid} !== 2'b10)
            $display("FAIL rstwait_pre: got %b want 10", {owner_lsu, mem_req_valid}); else n_pass++;
        rst = 1'b1; mem_resp_valid = 1'b1; #1;
        n_total++; if ({mem_req_valid, owner_lsu, ifu_resp_valid, lsu_resp_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== 73'h0)
            $display("FAIL rstwait_zero: got %b%b%b%b %h %b %h %h", mem_req_valid, owner_lsu, ifu_resp_valid, lsu_resp_valid, mem_addr, mem_wen, mem_wdata, mem_wmask); else n_pass++;
        @(negedge clk); rst = 1'b0; mem_resp_valid = 1'b0;
        @(negedge clk); mem_resp_valid = 1'b1; #1;
        n_total++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00)
            $display("FAIL rstwait_noresp: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); else n_pass++;
        @(negedge clk); mem_resp_valid = 1'b0; #1;
        n_total++; if (proto_err !== 1'b1)
            $display("FAIL rstwait_err: got %b want 1", proto_err); else n_pass++;
    endtask

    task automatic test_proto_err_idle();
        do_reset();
        mem_resp_valid = 1'b1; #1;
        n_total++; if ({proto_err, ifu_resp_valid, lsu_resp_valid} !== 3'b000)
            $display("FAIL perr_same: got %b want 000", {proto_err, ifu_resp_valid, lsu_resp_valid}); else n_pass++;
        @(negedge clk); mem_resp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004; mem_req_ready = 1'b1; #1;
        n_total++; if ({proto_err, ifu_req_ready} !== 2'b11)
            $display("FAIL perr_set: got %b want 11", {proto_err, ifu_req_ready}); else n_pass++;
        @(negedge clk); ifu_req_valid = 1'b0;
        @(negedge clk); mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0013; #1;
        n_total++; if ({ifu_resp_valid, ifu_rdata, proto_err} !== {1'b1, 32'h0000_0013, 1'b1})
            $display("FAIL perr_sticky: got %b %h %b want 1 00000013 1", ifu_resp_valid, ifu_rdata, proto_err); else n_pass++;
        @(negedge clk); mem_resp_valid = 1'b0; #1;
        n_total++; if (proto_err !== 1'b1)
            $display("FAIL perr_hold: got %b want 1", proto_err); else n_pass++;
        do_reset(); #1;
        n_total++; if (proto_err !== 1'b0)
            $display("FAIL perr_clear: got %b want 0", proto_err); else n_pass++;
    endtask

    task automatic test_random();
        logic pick_ifu, pick_lsu, exp_iresp, exp_lresp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            ifu_req_valid = ($urandom_range(0, 3) != 0); ifu_addr = $urandom;
            lsu_req_valid = ($urandom_range(0, 2) != 0); lsu_addr = $urandom;
            lsu_wen = $urandom_range(0, 1); lsu_wdata = $urandom; lsu_wmask = $urandom_range(0, 15);
            mem_req_ready = $urandom_range(0, 1);
            mem_resp_valid = (m_busy && m_issued) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
            mem_rdata = $urandom;
            #1;
            pick_ifu  = !m_busy && ifu_req_valid && (!lsu_req_valid || m_last_lsu);
            pick_lsu  = !m_busy && lsu_req_valid && !pick_ifu;
            exp_iresp = m_busy && m_issued && mem_resp_valid && !m_own_lsu;
            exp_lresp = m_busy && m_issued && mem_resp_valid && m_own_lsu;
            n_total++; if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, owner_lsu, proto_err}
                          !== {pick_ifu, pick_lsu, exp_iresp, exp_lresp, m_busy && !m_issued, m_own_lsu, m_err})
                $display("FAIL rand_ctrl[%0d]: got %b want %b", c,
                    {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, owner_lsu, proto_err},
                    {pick_ifu, pick_lsu, exp_iresp, exp_lresp, m_busy && !m_issued, m_own_lsu, m_err}); else n_pass++;
            n_total++; if ({mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata} !== {m_addr, m_wen, m_wdata, m_wmask, mem_rdata, mem_rdata})
                $display("FAIL rand_data[%0d]: got %h %b %h %h want %h %b %h %h", c,
                    mem_addr, mem_wen, mem_wdata, mem_wmask, m_addr, m_wen, m_wdata, m_wmask); else n_pass++;
            // Advance the model by one clock
            if (mem_resp_valid && !(m_busy && m_issued)) m_err = 1'b1;
            if (m_busy && m_issued && mem_resp_valid) m_busy = 1'b0;
            else if (m_busy && !m_issued && mem_req_ready) m_issued = 1'b1;
            if (pick_ifu) begin
                m_busy = 1'b1; m_issued = 1'b0; m_own_lsu = 1'b0; m_last_lsu = 1'b0;
                m_addr = ifu_addr; m_wen = 1'b0; m_wdata = 32'h0; m_wmask = 4'h0;
            end else if (pick_lsu) begin
                m_busy = 1'b1; m_issued = 1'b0; m_own_lsu = 1'b1; m_last_lsu = 1'b1;
                m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_alternate();
        test_store_stall();
        test_reset_in_wait();
        test_proto_err_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
